// File: rtl/s1.sv
//==============================================================================
// s1 : RB1 read/transpose, 8x21-bit serial send to S2, 18x13-bit return write-back
// Revision: 1.0
//==============================================================================
`default_nettype none

module s1 (
   input  logic       clk,
   input  logic       rst,
   input  logic       S2_done,
   output logic       S1_done,
   output logic       RB1_RW,
   output logic [4:0] RB1_A,
   output logic [7:0] RB1_D,
   input  logic [7:0] RB1_Q,
   inout  wire        sen,
   inout  wire        sd
);

   localparam logic [2:0] READ    = 3'd0;
   localparam logic [2:0] SEND    = 3'd1;
   localparam logic [2:0] GAP     = 3'd2;
   localparam logic [2:0] WAIT_S2 = 3'd3;
   localparam logic [2:0] RECV    = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   logic [2:0]  state, state_n;
   logic [4:0]  bit_idx, bit_idx_n;
   logic [2:0]  frame, frame_n;
   logic [17:0] words [8];
   logic [11:0] rx_shift;
   logic [3:0]  rx_cnt;
   logic [4:0]  wr_cnt;
   logic        sen_q, sd_q;
   logic        link_drive;
   logic [12:0] rx_frame;
   logic        rx_last;
   logic        wr_now;
   logic [20:0] tx_frame;
   logic        sen_d, sd_d, rw_d, done_d;
   logic [4:0]  a_d;
   logic [7:0]  d_d;

   // Tristate enables decode the current state so reset releases nothing.
   assign link_drive = (state == READ) || (state == SEND) || (state == GAP);
   assign sen        = link_drive ? sen_q : 1'bz;
   assign sd         = link_drive ? sd_q  : 1'bz;

   assign rx_frame = {rx_shift, sd};
   assign rx_last  = (state == RECV) && (sen == 1'b0) && (rx_cnt == 4'd12);
   assign wr_now   = (state == RECV) && !RB1_RW;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= READ;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      bit_idx_n = bit_idx;
      frame_n   = frame;
      case (state)
         READ: begin
            if (RB1_A == 5'd17) begin
               state_n   = SEND;
               bit_idx_n = 5'd0;
               frame_n   = 3'd0;
            end
         end
         SEND: begin
            if (bit_idx == 5'd20) state_n = GAP;
            else                  bit_idx_n = bit_idx + 5'd1;
         end
         GAP: begin
            if (frame == 3'd7) begin
               state_n = WAIT_S2;
            end else begin
               state_n   = SEND;
               frame_n   = frame + 3'd1;
               bit_idx_n = 5'd0;
            end
         end
         WAIT_S2: if (S2_done) state_n = RECV;
         RECV:    if (wr_now && (wr_cnt == 5'd17)) state_n = DONE;
         DONE:    state_n = DONE;
         default: state_n = READ;
      endcase
   end

   // Registered outputs are computed from the next state so they line up
   // with the cycle the state machine enters.
   always_comb begin
      tx_frame = {frame_n, words[frame_n]};
      sen_d    = 1'b1;
      sd_d     = 1'b0;
      if (state_n == SEND) begin
         sen_d = 1'b0;
         sd_d  = tx_frame[5'd20 - bit_idx_n];
      end
      rw_d = 1'b1;
      a_d  = RB1_A;
      d_d  = RB1_D;
      if (state == READ) a_d = (RB1_A == 5'd17) ? 5'd0 : RB1_A + 5'd1;
      if (rx_last && (rx_frame[12:8] < 5'd18)) begin
         rw_d = 1'b0;
         a_d  = rx_frame[12:8];
         d_d  = rx_frame[7:0];
      end
      done_d = (state == RECV) && (state_n == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_idx  <= 5'd0;
         frame    <= 3'd0;
         for (int j = 0; j < 8; j++) words[j] <= '0;
         rx_shift <= '0;
         rx_cnt   <= 4'd0;
         wr_cnt   <= 5'd0;
         sen_q    <= 1'b1;
         sd_q     <= 1'b0;
         RB1_RW   <= 1'b1;
         RB1_A    <= 5'd0;
         RB1_D    <= 8'd0;
         S1_done  <= 1'b0;
      end else begin
         bit_idx <= bit_idx_n;
         frame   <= frame_n;
         sen_q   <= sen_d;
         sd_q    <= sd_d;
         RB1_RW  <= rw_d;
         RB1_A   <= a_d;
         RB1_D   <= d_d;
         S1_done <= done_d;
         if (state == READ) begin
            for (int j = 0; j < 8; j++) words[j][5'd17 - RB1_A] <= RB1_Q[j];
         end
         if (state == WAIT_S2) begin
            rx_cnt <= 4'd0;
            wr_cnt <= 5'd0;
         end
         if (state == RECV) begin
            // A high sen mid-frame drops the partial frame.
            if (sen == 1'b0) begin
               rx_shift <= rx_frame[11:0];
               rx_cnt   <= rx_last ? 4'd0 : rx_cnt + 4'd1;
            end else begin
               rx_cnt <= 4'd0;
            end
            if (wr_now) wr_cnt <= wr_cnt + 5'd1;
         end
      end
   end

endmodule

`default_nettype wire
